// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and address-field helpers for the direct-mapped instruction cache
package icache_pkg;

    // Controller state: RUN looks up, REFILL bursts one line from the bus, RESP answers the missed fetch.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Field widths derived from the geometry parameters.
    function automatic int calc_off_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int wpl);
        return addr_w - 2 - $clog2(wpl) - $clog2(lines);
    endfunction

    // Field extraction from a byte PC (zero-extended to 64 bits); callers size-cast the result.
    function automatic logic [63:0] pc_offset(input logic [63:0] pc, input int wpl);
        return (pc >> 2) & 64'(wpl - 1);
    endfunction

    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int lines, input int wpl);
        return (pc >> (2 + $clog2(wpl))) & 64'(lines - 1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int lines, input int wpl);
        return pc >> (2 + $clog2(wpl) + $clog2(lines));
    endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and refill-bus signals of the instruction cache
//
// Fetch side : req_valid/req_pc/req_ready request, resp_valid/resp_instr answer.
// Bus side   : mem_addr/mem_ren read strobe, mem_rdata/mem_done completion.
// slave  modport : the cache itself.
// master modport : the environment (fetch stage plus shared bus).
interface icache_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_instr;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [31:0]       mem_rdata;
    logic              mem_done;

    modport slave (
        input  req_valid, req_pc, mem_rdata, mem_done,
        output req_ready, resp_valid, resp_instr, mem_addr, mem_ren
    );

    modport master (
        output req_valid, req_pc, mem_rdata, mem_done,
        input  req_ready, resp_valid, resp_instr, mem_addr, mem_ren
    );
endinterface

// File: rtl/icache_data_ram.sv
// rtl/icache_data_ram.sv - simple dual-port 32-bit synchronous RAM holding the cache lines
//
// Ports: clk; we_i/waddr_i/wdata_i refill write port; raddr_i lookup read address;
//        rdata_o registered read data (one cycle after raddr_i).
module icache_data_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // No reset on the array or the read register so the block maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped L1 instruction cache with line refill, invalidate and hit/miss counters
//
// Ports: clk; rst (synchronous, active-high); bus (icache_if.slave: fetch request/response and
//        refill bus); invalidate (one-cycle pulse clearing every valid bit);
//        hit_count/miss_count (wrapping counts of accepted requests that hit/missed).
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES          = 256,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     bus,
    input  logic        invalidate,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES, WORDS_PER_LINE);

    state_e             state_q, state_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               kill_q, kill_d;
    logic [31:0]        cap_q, cap_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;
    logic [TAG_W-1:0]   tag_q [LINES];

    logic [IDX_W-1:0]   lk_idx;
    logic [OFF_W-1:0]   lk_off;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   rd_idx;
    logic [OFF_W-1:0]   rd_off;
    logic               hit, miss, accept, refill_last;
    logic [31:0]        ram_rdata;

    // Fields of the request currently being compared (or refilled).
    assign lk_idx = IDX_W'(pc_index(64'(pc_q), LINES, WORDS_PER_LINE));
    assign lk_off = OFF_W'(pc_offset(64'(pc_q), WORDS_PER_LINE));
    assign lk_tag = TAG_W'(pc_tag(64'(pc_q), LINES, WORDS_PER_LINE));

    // The data RAM is read every cycle at the presented PC, so its output is
    // ready for the compare cycle of whichever request was accepted.
    assign rd_idx = IDX_W'(pc_index(64'(bus.req_pc), LINES, WORDS_PER_LINE));
    assign rd_off = OFF_W'(pc_offset(64'(bus.req_pc), WORDS_PER_LINE));

    // Compare uses the current valid bits, so an invalidate in the same cycle
    // only affects later lookups.
    assign hit  = (state_q == RUN) && pend_q && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign miss = (state_q == RUN) && pend_q && !hit;

    // A new request may enter whenever the compare stage is empty or hitting,
    // and during the single response cycle after a refill.
    assign bus.req_ready = ((state_q == RUN) && (!pend_q || hit)) || (state_q == RESP);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.resp_valid = hit || (state_q == RESP);
    assign bus.resp_instr = (state_q == RESP) ? cap_q : ram_rdata;

    assign bus.mem_ren  = (state_q == REFILL);
    assign bus.mem_addr = (state_q == REFILL) ? {pc_q[ADDR_W-1:OFF_W+2], cnt_q, 2'b00} : '0;

    // mem_done only matters while a refill read is outstanding.
    assign refill_last = (state_q == REFILL) && bus.mem_done && (cnt_q == {OFF_W{1'b1}});

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    icache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (IDX_W + OFF_W)
    ) u_data_ram (
        .clk     (clk),
        .we_i    ((state_q == REFILL) && bus.mem_done),
        .waddr_i ({lk_idx, cnt_q}),
        .wdata_i (bus.mem_rdata),
        .raddr_i ({rd_idx, rd_off}),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = accept;
        pc_d       = accept ? bus.req_pc : pc_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        cap_d      = cap_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            RUN: begin
                if (hit) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end else if (miss) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    // The line is about to be overwritten word by word; drop its old tag now.
                    valid_d[lk_idx] = 1'b0;
                    cnt_d   = '0;
                    kill_d  = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                // An invalidate during the burst must not let this line survive it.
                if (invalidate) begin
                    kill_d = 1'b1;
                end
                if (bus.mem_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == lk_off) begin
                        cap_d = bus.mem_rdata;
                    end
                    if (refill_last) begin
                        valid_d[lk_idx] = !(kill_q || invalidate);
                        kill_d  = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (invalidate) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pend_q     <= 1'b0;
            pc_q       <= '0;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            cap_q      <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            kill_q     <= kill_d;
            cap_q      <= cap_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag array has no reset; the valid vector alone decides whether a tag means anything.
    always_ff @(posedge clk) begin
        if (!rst && refill_last) begin
            tag_q[lk_idx] <= lk_tag;
        end
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped L1 instruction cache; successor to the core-local progMEM instruction store.
- Sits between the pipelined core's fetch stage and the shared bus, using the same ren/rdata/done handshake as the data path.
- Lets program and data share one memory while keeping single-cycle fetch on a hit.
- Adds line refill, whole-cache invalidate (fence.i) and hit/miss performance counters.

Parameters:
- LINES, 256, number of cache lines (power of two, >=2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, >=2)
- ADDR_W, 32, byte address width
- Derived: OFF_W = log2(WORDS_PER_LINE); IDX_W = log2(LINES); TAG_W = ADDR_W - 2 - OFF_W - IDX_W

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  fetch request
- req_pc  in  ADDR_W  byte PC; bits [1:0] ignored
- req_ready  out  1  request accepted when req_valid & req_ready
- resp_valid  out  1  resp_instr valid this cycle
- resp_instr  out  32  instruction word
- invalidate  in  1  one-cycle pulse: clear all valid bits
- mem_addr  out  ADDR_W  word-aligned refill address
- mem_ren  out  1  refill read strobe, held until mem_done
- mem_rdata  in  32  refill data, valid with mem_done
- mem_done  in  1  bus completion
- hit_count  out  32  accepted requests that hit (wraps)
- miss_count  out  32  accepted requests that missed (wraps)

Behaviour:
- Reset:
  - state=RUN; all valid bits 0; req_ready=1; resp_valid=0; mem_ren=0; mem_addr=0; counters=0.
  - rst mid-refill: mem_ren drops the next edge; the partial line is discarded; no response is issued.
- Storage:
  - data array of LINES*WORDS_PER_LINE words with synchronous read (must infer BRAM).
  - tag array of LINES x TAG_W; valid vector of LINES flops.
- Lookup pipeline:
  - Accept in cycle N (latch pc, read arrays).
  - Cycle N+1: compare. On a hit, resp_valid=1 with the word at pc, and hit_count increments.
  - req_ready in N+1 = hit, or no request pending, so back-to-back hits sustain 1 instr/cycle.
- Miss, cycle N+1:
  - resp_valid=0, req_ready=0, miss_count increments; go to REFILL with word counter=0.
- REFILL:
  - mem_addr = {tag,idx,cnt,2'b00}; mem_ren=1.
  - On each mem_done: write mem_rdata into the data array at {idx,cnt}, capture the word if cnt equals the pc offset, then cnt++.
  - mem_done with mem_ren=0 is ignored.
  - After the last word's mem_done: write the tag, set valid (unless killed), go to RESP.
- RESP (1 cycle):
  - resp_valid=1 with the captured word, req_ready=1, return to RUN.
  - Miss latency = 2 + WORDS_PER_LINE*(bus latency) cycles from accept.
- invalidate:
  - In RUN: all valid bits clear at the edge. A lookup compared in that same cycle still uses the old valid bits.
  - In REFILL: the bus burst completes (no abort) and a sticky kill flag is set; at the end the line is NOT marked valid, but the pending response is still delivered; the flag is cleared.
- Flush of an issued request: the core must not deassert or change req_pc after acceptance; the cache always answers each accepted request exactly once.
- Counters wrap at 2^32; each accepted request is counted exactly once.
- Simultaneous invalidate and hit in the same cycle: the response is delivered; the next access to that line misses.

Decomposition:
- Package icache_pkg:
  - state enum {RUN, REFILL, RESP};
  - localparam helper functions for OFF_W/IDX_W/TAG_W;
  - field-extract functions for tag/idx/offset.
- Sub-module icache_data_ram (byte-less 32-bit simple dual-port sync RAM, write port for refill, read port for lookup).
- Tag/valid logic and the FSM stay in the top-level module.

Test Plan:
- Cold miss: LINES=4, WPL=4, bus latency 1. Fetch 0x10 -> four reads 0x10,0x14,0x18,0x1C; resp_valid with the word at 0x10; miss_count=1.
- Streaming hits: after the cold miss, fetch 0x14, 0x18, 0x1C in consecutive cycles -> three responses on consecutive cycles, no mem_ren, hit_count=3.
- Conflict eviction: fetch 0x00, then 0x40 (same idx, LINES=4, WPL=4), then 0x00 -> three misses, refill addresses 0x00..0x0C, 0x40..0x4C, 0x00..0x0C.
- Invalidate during refill: pulse invalidate while cnt=2 on a miss to 0x20 -> refill finishes, response delivered, next fetch of 0x20 misses again.
- Stalling bus: mem_done delayed 5 cycles per word -> mem_ren and mem_addr stay stable until each done; resp arrives 2+4*5 cycles after accept.
- Reset mid-refill: rst after the second word -> mem_ren=0 the next cycle, no resp_valid, counters=0, the following fetch misses.
